// File: rtl/jtag_reg_master_if.sv
// Request/response handshake between a register client and jtag_reg_master.
// The client drives requests (master); jtag_reg_master serves them (slave).
interface jtag_reg_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/jtag_reg_master.sv
// On-chip Virtual JTAG initiator: turns register write/read requests into
// IR/CAPTURE/SHIFT/UPDATE/GAP frame sequences toward the register bridge.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | waiting for a request, req_ready = 1
// S_IR      | one tck cycle presenting ir_out, no strobes
// S_CAPTURE | one tck cycle with vs_cdr = 1
// S_SHIFT   | DRW tck cycles with vs_sdr = 1, tdi = frame bit bit_cnt
// S_UPDATE  | one tck cycle with vs_udr = 1
// S_GAP     | GAP_TCK idle tck cycles so the bridge CDC can settle
// S_RESP    | one clk_sys cycle rsp_valid pulse; a new request may be taken
module jtag_reg_master #(
  parameter int TCK_DIV = 2,
  parameter int GAP_TCK = 8,
  parameter int DRW     = 40
) (
  input  logic               clk_sys,
  input  logic               rst_sys_n,
  jtag_reg_master_if.slave   bus,
  output logic               tck,
  output logic               tdi,
  output logic [1:0]         ir_out,
  output logic               vs_cdr,
  output logic               vs_sdr,
  output logic               vs_udr,
  input  logic               tdo
);

  localparam int DIVW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam int BMAX = (DRW > GAP_TCK) ? DRW : GAP_TCK;
  localparam int BITW = $clog2(BMAX);

  localparam logic [DIVW-1:0] DIV_LAST   = DIVW'(TCK_DIV - 1);
  localparam logic [BITW-1:0] SHIFT_LAST = BITW'(DRW - 1);
  localparam logic [BITW-1:0] GAP_LAST   = BITW'(GAP_TCK - 1);
  localparam logic [1:0]      IR_WRITE   = 2'b01;
  localparam logic [1:0]      IR_READ    = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_IR, S_CAPTURE, S_SHIFT, S_UPDATE, S_GAP, S_RESP
  } state_t;

  state_t          state;
  logic [DIVW-1:0] div_cnt;
  logic [BITW-1:0] bit_cnt;
  logic            frame_idx;
  logic            wr_q;
  logic [7:0]      addr_q;
  logic [31:0]     wdata_q;
  logic [DRW-1:0]  sh_q;
  logic [DRW-1:0]  cap_q;
  logic            req_ready_q;
  logic            busy_q;
  logic            rsp_valid_q;
  logic [31:0]     rsp_rdata_q;
  logic            rsp_err_q;
  logic [DRW-1:0]  frame_word;

  // Reads shift an all-zero payload; the bridge only looks at the address.
  assign frame_word = {(wr_q ? wdata_q : 32'd0), addr_q};

  assign bus.req_ready = req_ready_q;
  assign bus.busy      = busy_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  // Frame sequencer: tck divider, per-tck-cycle state advance and response.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state       <= S_IDLE;
      div_cnt     <= '0;
      bit_cnt     <= '0;
      frame_idx   <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      sh_q        <= '0;
      cap_q       <= '0;
      tck         <= 1'b0;
      tdi         <= 1'b0;
      ir_out      <= 2'b00;
      vs_cdr      <= 1'b0;
      vs_sdr      <= 1'b0;
      vs_udr      <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state)
        S_IDLE, S_RESP: begin
          if (bus.req_valid) begin
            // First low phase of tck starts right on this edge.
            wr_q        <= bus.req_write;
            addr_q      <= bus.req_addr;
            wdata_q     <= bus.req_wdata;
            frame_idx   <= 1'b0;
            ir_out      <= bus.req_write ? IR_WRITE : IR_READ;
            tck         <= 1'b0;
            div_cnt     <= '0;
            busy_q      <= 1'b1;
            req_ready_q <= 1'b0;
            state       <= S_IR;
          end else begin
            state <= S_IDLE;
          end
        end
        default: begin
          if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + 1'b1;
          end else if (!tck) begin
            // Rising tck: tdo still holds the bit the bridge is about to shift.
            div_cnt <= '0;
            tck     <= 1'b1;
            if (state == S_SHIFT && !wr_q && frame_idx)
              cap_q <= {tdo, cap_q[DRW-1:1]};
          end else begin
            // Falling tck: every JTAG-side output changes only here.
            div_cnt <= '0;
            tck     <= 1'b0;
            case (state)
              S_IR: begin
                sh_q   <= frame_word;
                vs_cdr <= 1'b1;
                state  <= S_CAPTURE;
              end
              S_CAPTURE: begin
                vs_cdr  <= 1'b0;
                vs_sdr  <= 1'b1;
                tdi     <= sh_q[0];
                sh_q    <= sh_q >> 1;
                bit_cnt <= '0;
                state   <= S_SHIFT;
              end
              S_SHIFT: begin
                if (bit_cnt == SHIFT_LAST) begin
                  vs_sdr <= 1'b0;
                  tdi    <= 1'b0;
                  vs_udr <= 1'b1;
                  state  <= S_UPDATE;
                end else begin
                  bit_cnt <= bit_cnt + 1'b1;
                  tdi     <= sh_q[0];
                  sh_q    <= sh_q >> 1;
                end
              end
              S_UPDATE: begin
                vs_udr  <= 1'b0;
                bit_cnt <= '0;
                state   <= S_GAP;
              end
              S_GAP: begin
                if (bit_cnt != GAP_LAST) begin
                  bit_cnt <= bit_cnt + 1'b1;
                end else if (!wr_q && !frame_idx) begin
                  // Address now latched in the bridge; second frame reads it.
                  frame_idx <= 1'b1;
                  state     <= S_IR;
                end else begin
                  rsp_valid_q <= 1'b1;
                  req_ready_q <= 1'b1;
                  busy_q      <= 1'b0;
                  ir_out      <= 2'b00;
                  rsp_rdata_q <= wr_q ? 32'd0 : cap_q[DRW-1:8];
                  rsp_err_q   <= wr_q ? 1'b0 : (cap_q[7:0] != addr_q);
                  state       <= S_RESP;
                end
              end
              default: state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_reg_master.sv
// Bench for jtag_reg_master: two instances (TCK_DIV=2 and TCK_DIV=1, GAP_TCK=4)
// driving a behavioural register-bridge model, checked against a reference
// register map and the frame-length latency formula.
module tb_jtag_reg_master;

  localparam int GAP   = 4;
  localparam int NF    = 43 + GAP;
  localparam int LW_D2 = 2 * 2 * NF + 1;
  localparam int LR_D2 = 2 * 2 * 2 * NF + 1;
  localparam int LW_D1 = 2 * 1 * NF + 1;
  localparam int LR_D1 = 2 * 1 * 2 * NF + 1;

  logic clk_sys = 1'b0;
  logic rst_sys_n = 1'b1;
  always #5 clk_sys = ~clk_sys;

  jtag_reg_master_if bif0 ();
  jtag_reg_master_if bif1 ();

  logic       tck0, tdi0, cdr0, sdr0, udr0, tdo0;
  logic       tck1, tdi1, cdr1, sdr1, udr1, tdo1;
  logic [1:0] ir0, ir1;

  jtag_reg_master #(.TCK_DIV(2), .GAP_TCK(GAP), .DRW(40)) u_dut0 (
    .clk_sys(clk_sys), .rst_sys_n(rst_sys_n), .bus(bif0.slave),
    .tck(tck0), .tdi(tdi0), .ir_out(ir0),
    .vs_cdr(cdr0), .vs_sdr(sdr0), .vs_udr(udr0), .tdo(tdo0)
  );

  jtag_reg_master #(.TCK_DIV(1), .GAP_TCK(GAP), .DRW(40)) u_dut1 (
    .clk_sys(clk_sys), .rst_sys_n(rst_sys_n), .bus(bif1.slave),
    .tck(tck1), .tdi(tdi1), .ir_out(ir1),
    .vs_cdr(cdr1), .vs_sdr(sdr1), .vs_udr(udr1), .tdo(tdo1)
  );

  // ---------------- bridge model and monitors ----------------
  logic [39:0] br_dr        [2];
  logic [31:0] br_reg       [2][256];
  logic [7:0]  br_alat      [2];
  logic [39:0] br_last_word [2];
  logic [1:0]  br_last_ir   [2];
  int          br_rd_frames [2];
  int          br_scnt      [2];
  logic        br_init_done = 1'b0;
  logic        br_fault;
  logic        tck0_q = 1'b0, tck1_q = 1'b0, busy1_q = 1'b0;
  logic        mon_en;
  int          low_run = 0, max_low = 0, tog_err = 0, rsp_cnt0 = 0;
  int          cyc = 0;

  assign tdo0 = br_dr[0][0];
  assign tdo1 = br_dr[1][0];

  always @(posedge clk_sys) cyc++;

  task automatic bridge_edge(input int k, input logic cdr, input logic sdr,
                             input logic udr, input logic [1:0] ir, input logic d);
    if (cdr) begin
      br_dr[k]   = {br_reg[k][br_alat[k]], br_alat[k]};
      br_scnt[k] = 0;
    end else if (sdr) begin
      br_dr[k] = {d, br_dr[k][39:1]};
      br_scnt[k]++;
    end else if (udr) begin
      br_last_word[k] = br_dr[k];
      br_last_ir[k]   = ir;
      if (ir == 2'b01) begin
        br_reg[k][br_dr[k][7:0]] = br_dr[k][39:8];
      end else if (ir == 2'b10) begin
        br_alat[k] = br_fault ? br_dr[k][7:0] + 8'd1 : br_dr[k][7:0];
        br_rd_frames[k]++;
      end
    end
  endtask

  // Bridge reacts to tck rising edges, seen half a clk_sys cycle later.
  always @(negedge clk_sys) begin
    if (!br_init_done) begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 256; i++)
          br_reg[k][i] = (i == 16) ? 32'h1234_5678 : (32'hA500_0000 | 32'(i));
        br_dr[k] = '0; br_alat[k] = '0; br_last_word[k] = '0;
        br_last_ir[k] = '0; br_rd_frames[k] = 0; br_scnt[k] = 0;
      end
      br_init_done = 1'b1;
    end
    if (tck0 && !tck0_q) bridge_edge(0, cdr0, sdr0, udr0, ir0, tdi0);
    if (tck1 && !tck1_q) bridge_edge(1, cdr1, sdr1, udr1, ir1, tdi1);
    if (mon_en) begin
      low_run = tck0 ? 0 : low_run + 1;
      if (low_run > max_low) max_low = low_run;
    end
    if (bif1.busy && busy1_q && (tck1 == tck1_q)) tog_err++;
    if (bif0.rsp_valid) rsp_cnt0++;
    tck0_q  = tck0;
    tck1_q  = tck1;
    busy1_q = bif1.busy;
  end

  // ---------------- checking helpers ----------------
  int n_checks = 0, n_pass = 0, n_fail = 0;
  logic [31:0] ref_mem [256];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int k, input logic v, input logic w,
                         input logic [7:0] a, input logic [31:0] d);
    if (k == 0) begin
      bif0.req_valid = v; bif0.req_write = w; bif0.req_addr = a; bif0.req_wdata = d;
    end else begin
      bif1.req_valid = v; bif1.req_write = w; bif1.req_addr = a; bif1.req_wdata = d;
    end
  endtask

  function automatic logic get_ready(input int k);
    return (k == 0) ? bif0.req_ready : bif1.req_ready;
  endfunction

  function automatic logic get_rsp(input int k);
    return (k == 0) ? bif0.rsp_valid : bif1.rsp_valid;
  endfunction

  // Called at a negedge; returns at the negedge where rsp_valid is seen.
  // Latency counts from the handshake cycle to the rsp_valid cycle.
  task automatic run_txn(input int k, input logic w, input logic [7:0] a,
                         input logic [31:0] d, output logic [31:0] rd,
                         output logic er, output int lat);
    int n;
    int c0;
    set_req(k, 1'b1, w, a, d);
    n = 0;
    while (!get_ready(k) && n < 1000) begin @(negedge clk_sys); n++; end
    c0 = cyc;
    @(negedge clk_sys);
    set_req(k, 1'b0, w, a, d);
    n = 0;
    while (!get_rsp(k) && n < 2000) begin @(negedge clk_sys); n++; end
    lat = cyc - c0;
    rd  = (k == 0) ? bif0.rsp_rdata : bif1.rsp_rdata;
    er  = (k == 0) ? bif0.rsp_err : bif1.rsp_err;
  endtask

  function automatic logic [12:0] reset_vec0();
    return {tck0, tdi0, ir0, cdr0, sdr0, udr0, bif0.req_ready, bif0.busy,
            bif0.rsp_valid, bif0.rsp_err, 2'b00};
  endfunction

  localparam logic [12:0] RST_VEC = {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0,
                                     1'b1, 1'b0, 1'b0, 1'b0, 2'b00};

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + randomized sequence ----------------
  initial begin
    logic [31:0] rd, wd, d;
    logic        er, w;
    logic [7:0]  a;
    int          lat, c0, n, frames0, base;

    br_fault = 1'b0;
    mon_en   = 1'b0;
    set_req(0, 1'b0, 1'b0, 8'h00, 32'h0);
    set_req(1, 1'b0, 1'b0, 8'h00, 32'h0);
    for (int i = 0; i < 256; i++)
      ref_mem[i] = (i == 16) ? 32'h1234_5678 : (32'hA500_0000 | 32'(i));

    #1 rst_sys_n = 1'b0;
    #2;
    check("reset_outputs", 64'(reset_vec0()), 64'(RST_VEC));
    check("reset_rdata", 64'(bif0.rsp_rdata), 64'h0);
    check("reset_ready1", 64'(bif1.req_ready), 64'h1);
    repeat (3) @(negedge clk_sys);
    rst_sys_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    // Write 0x40 to 0x01
    run_txn(0, 1'b1, 8'h01, 32'h0000_0040, rd, er, lat);
    ref_mem[8'h01] = 32'h0000_0040;
    check("wr_latency", 64'(lat), 64'(LW_D2));
    check("wr_rdata", 64'(rd), 64'h0);
    check("wr_err", 64'(er), 64'h0);
    check("wr_tdi_word", 64'(br_last_word[0]), 64'h00_0000_4001);
    check("wr_ir", 64'(br_last_ir[0]), 64'h1);
    check("wr_bridge_reg", 64'(br_reg[0][8'h01]), 64'(ref_mem[8'h01]));

    // Read 0x10
    frames0 = br_rd_frames[0];
    run_txn(0, 1'b0, 8'h10, 32'hDEAD_BEEF, rd, er, lat);
    check("rd_latency", 64'(lat), 64'(LR_D2));
    check("rd_rdata", 64'(rd), 64'(ref_mem[8'h10]));
    check("rd_err", 64'(er), 64'h0);
    check("rd_frames", 64'(br_rd_frames[0] - frames0), 64'd2);
    check("rd_ir", 64'(br_last_ir[0]), 64'h2);
    check("rd_tdi_word", 64'(br_last_word[0]), 64'h00_0000_0010);

    // Bridge latches the wrong address: error flagged, data of 0x11 returned
    br_fault = 1'b1;
    run_txn(0, 1'b0, 8'h10, 32'h0, rd, er, lat);
    br_fault = 1'b0;
    check("mis_err", 64'(er), 64'h1);
    check("mis_rdata", 64'(rd), 64'(ref_mem[8'h11]));

    // Back-to-back write then read with req_valid held high
    wd = $urandom;
    set_req(0, 1'b1, 1'b1, 8'h42, wd);
    n = 0;
    while (!bif0.req_ready && n < 1000) begin @(negedge clk_sys); n++; end
    c0 = cyc;
    @(negedge clk_sys);
    max_low = 0; low_run = 0; mon_en = 1'b1;
    set_req(0, 1'b1, 1'b0, 8'h42, 32'h0);
    n = 0;
    while (!bif0.rsp_valid && n < 2000) begin @(negedge clk_sys); n++; end
    ref_mem[8'h42] = wd;
    check("b2b_wr_latency", 64'(cyc - c0), 64'(LW_D2));
    check("b2b_ready_in_rsp", 64'(bif0.req_ready), 64'h1);
    c0 = cyc;
    @(negedge clk_sys);
    check("b2b_accepted", 64'({bif0.busy, bif0.rsp_valid}), 64'b10);
    set_req(0, 1'b0, 1'b0, 8'h42, 32'h0);
    n = 0;
    while (!bif0.rsp_valid && n < 2000) begin @(negedge clk_sys); n++; end
    mon_en = 1'b0;
    check("b2b_rd_latency", 64'(cyc - c0), 64'(LR_D2));
    check("b2b_rdata", 64'(bif0.rsp_rdata), 64'(ref_mem[8'h42]));
    check("b2b_err", 64'(bif0.rsp_err), 64'h0);
    check("b2b_tck_max_low", 64'(max_low), 64'd3);

    // Randomized transactions against the reference register map
    for (int t = 0; t < 8; t++) begin
      w = 1'($urandom_range(0, 1));
      a = 8'h30 + 8'($urandom_range(0, 3));
      d = $urandom;
      run_txn(0, w, a, d, rd, er, lat);
      if (w) ref_mem[a] = d;
      check("rnd_rdata", 64'(rd), w ? 64'h0 : 64'(ref_mem[a]));
      check("rnd_err", 64'(er), 64'h0);
      check("rnd_latency", 64'(lat), w ? 64'(LW_D2) : 64'(LR_D2));
    end

    // Reset pulse in the middle of SHIFT bit 20 of a write
    a = 8'h22;
    d = ~ref_mem[a];
    set_req(0, 1'b1, 1'b1, a, d);
    n = 0;
    while (!bif0.req_ready && n < 1000) begin @(negedge clk_sys); n++; end
    @(negedge clk_sys);
    set_req(0, 1'b0, 1'b1, a, d);
    n = 0;
    while (!(sdr0 && br_scnt[0] == 20 && !tck0) && n < 2000) begin
      @(negedge clk_sys); n++;
    end
    check("rst_reached_bit20", 64'(br_scnt[0]), 64'd20);
    base = rsp_cnt0;
    #2 rst_sys_n = 1'b0;
    #1;
    check("rst_mid_outputs", 64'(reset_vec0()), 64'(RST_VEC));
    check("rst_mid_rdata", 64'(bif0.rsp_rdata), 64'h0);
    @(negedge clk_sys);
    rst_sys_n = 1'b1;
    repeat (250) @(negedge clk_sys);
    check("rst_no_rsp", 64'(rsp_cnt0 - base), 64'd0);
    check("rst_reg_unchanged", 64'(br_reg[0][a]), 64'(ref_mem[a]));
    run_txn(0, 1'b1, a, d, rd, er, lat);
    ref_mem[a] = d;
    check("post_rst_latency", 64'(lat), 64'(LW_D2));
    check("post_rst_reg", 64'(br_reg[0][a]), 64'(ref_mem[a]));

    // TCK_DIV = 1 instance
    wd = $urandom;
    tog_err = 0;
    run_txn(1, 1'b1, 8'h05, wd, rd, er, lat);
    check("d1_wr_latency", 64'(lat), 64'(LW_D1));
    check("d1_reg", 64'(br_reg[1][8'h05]), 64'(wd));
    check("d1_tdi_word", 64'(br_last_word[1]), 64'({wd, 8'h05}));
    check("d1_tck_toggle", 64'(tog_err), 64'd0);
    run_txn(1, 1'b0, 8'h05, 32'h0, rd, er, lat);
    check("d1_rd_latency", 64'(lat), 64'(LR_D1));
    check("d1_rdata", 64'(rd), 64'(wd));
    check("d1_err", 64'(er), 64'h0);

    repeat (4) @(negedge clk_sys);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
